// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg: instruction classes and the class-to-control-word mapping.
`include "constants.vh"
package instr_decode_pkg;
    typedef enum logic [3:0] {
        C_ILL, C_ADD, C_SUB, C_AND, C_ORR, C_LSL, C_LSR,
        C_ADDI, C_SUBI, C_LDUR, C_STUR, C_B, C_CBZ, C_CBNZ
    } iclass_t;
    typedef struct packed {
        logic reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, illegal;
        logic [3:0] alu_ctrl;
    } ctrl_t;
    function automatic iclass_t classify(input logic [31:0] i);
        if (i[31:21] == `OP_ADD) return C_ADD;
        if (i[31:21] == `OP_SUB) return C_SUB;
        if (i[31:21] == `OP_AND) return C_AND;
        if (i[31:21] == `OP_ORR) return C_ORR;
        if (i[31:21] == `OP_LSL) return C_LSL;
        if (i[31:21] == `OP_LSR) return C_LSR;
        if (i[31:21] == `OP_LDUR) return C_LDUR;
        if (i[31:21] == `OP_STUR) return C_STUR;
        if (i[31:22] == `OP_ADDI) return C_ADDI;
        if (i[31:22] == `OP_SUBI) return C_SUBI;
        if (i[31:26] == `OP_B) return C_B;
        if (i[31:24] == `OP_CBZ) return C_CBZ;
        if (i[31:24] == `OP_CBNZ) return C_CBNZ;
        return C_ILL;
    endfunction
    function automatic ctrl_t ctrl_of(input iclass_t c);
        ctrl_t k;
        k = '0;
        k.reg_write = c inside {C_ADD, C_SUB, C_AND, C_ORR, C_LSL, C_LSR, C_ADDI, C_SUBI, C_LDUR};
        k.mem_read = c == C_LDUR;
        k.mem_to_reg = c == C_LDUR;
        k.mem_write = c == C_STUR;
        k.alu_src = c inside {C_ADDI, C_SUBI, C_LDUR, C_STUR, C_LSL, C_LSR};
        k.branch = c inside {C_CBZ, C_CBNZ};
        k.uncond_branch = c == C_B;
        k.illegal = c == C_ILL;
        k.alu_ctrl = c == C_AND ? `ALU_AND :
                     c == C_ORR ? `ALU_ORR :
                     c inside {C_ADD, C_ADDI, C_LDUR, C_STUR} ? `ALU_ADD :
                     c inside {C_SUB, C_SUBI} ? `ALU_SUB :
                     c inside {C_CBZ, C_CBNZ} ? `ALU_PASSB :
                     c == C_LSL ? `ALU_LSL :
                     c == C_LSR ? `ALU_LSR : 4'b0000;
        return k;
    endfunction
    // Stores and compare-branches read their second operand from the Rt field.
    function automatic logic rs2_from_rt(input iclass_t c);
        return c inside {C_STUR, C_CBZ, C_CBNZ};
    endfunction
    function automatic logic uses_rs2(input iclass_t c);
        return c inside {C_ADD, C_SUB, C_AND, C_ORR, C_STUR, C_CBZ, C_CBNZ};
    endfunction
endpackage

// File: rtl/constants.vh
// constants.vh: datapath width, opcode patterns and ALU control codes shared by decode and execute.
`ifndef CONSTANTS_VH
`define CONSTANTS_VH
`define WORD      64
`define OP_ADD    11'b10001011000
`define OP_SUB    11'b11001011000
`define OP_AND    11'b10001010000
`define OP_ORR    11'b10101010000
`define OP_LSL    11'b11010011011
`define OP_LSR    11'b11010011010
`define OP_LDUR   11'b11111000010
`define OP_STUR   11'b11111000000
`define OP_ADDI   10'b1001000100
`define OP_SUBI   10'b1101000100
`define OP_B      6'b000101
`define OP_CBZ    8'b10110100
`define OP_CBNZ   8'b10110101
`define ALU_AND   4'b0000
`define ALU_ORR   4'b0001
`define ALU_ADD   4'b0010
`define ALU_SUB   4'b0110
`define ALU_PASSB 4'b0111
`define ALU_LSL   4'b0011
`define ALU_LSR   4'b0100
`endif

// File: rtl/sign_extend.sv
// sign_extend: builds the WORD-wide immediate for each instruction class.
`include "constants.vh"
module sign_extend
    import instr_decode_pkg::*;
(
    input  logic [31:0]       instr,
    input  iclass_t           cls,
    output logic [`WORD-1:0]  imm
);
    always_comb begin
        imm = '0;
        case (cls)
            C_ADDI, C_SUBI: imm = {{(`WORD-12){1'b0}}, instr[21:10]};
            C_LDUR, C_STUR: imm = {{(`WORD-9){instr[20]}}, instr[20:12]};
            C_B:            imm = {{(`WORD-28){instr[25]}}, instr[25:0], 2'b00};
            C_CBZ, C_CBNZ:  imm = {{(`WORD-21){instr[23]}}, instr[23:5], 2'b00};
            C_LSL, C_LSR:   imm = {{(`WORD-6){1'b0}}, instr[15:10]};
            default:        imm = '0;
        endcase
    end
endmodule

// File: rtl/instr_decode.sv
// instr_decode: registered decode stage with valid/ready handshake and a RAW scoreboard.
`include "constants.vh"
module instr_decode
    import instr_decode_pkg::*;
#(
    parameter bit SB_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        read_reg1,
    output logic [4:0]        read_reg2,
    output logic [4:0]        write_reg,
    output logic [`WORD-1:0]  imm,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_src,
    output logic              branch,
    output logic              uncond_branch,
    output logic              illegal,
    output logic [3:0]        alu_ctrl,
    input  logic              wb_valid,
    input  logic [4:0]        wb_reg,
    input  logic              flush
);
    logic [31:0]       busy, set_mask, clr_mask;
    iclass_t           cls;
    ctrl_t             ctrl;
    logic [4:0]        rs1, rs2;
    logic [`WORD-1:0]  imm_d;
    logic              hazard, accept;

    assign cls = classify(in_instr);
    assign ctrl = ctrl_of(cls);
    assign rs1 = in_instr[9:5];
    assign rs2 = rs2_from_rt(cls) ? in_instr[4:0] : in_instr[20:16];
    assign hazard = SB_EN && in_valid && (busy[rs1] || (uses_rs2(cls) && busy[rs2]));
    assign in_ready = rst_n && (!out_valid || out_ready) && !hazard && !flush;
    assign accept = in_valid && in_ready;

    // XZR is never marked busy; a same-edge set overrides any clear.
    assign set_mask = accept && ctrl.reg_write && in_instr[4:0] != 5'd31 ? 32'b1 << in_instr[4:0] : '0;
    assign clr_mask = (wb_valid ? 32'b1 << wb_reg : '0) |
                      (flush && out_valid && reg_write ? 32'b1 << write_reg : '0);

    sign_extend u_sign_extend (.instr(in_instr), .cls(cls), .imm(imm_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= (busy & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            read_reg1 <= '0;
            read_reg2 <= '0;
            write_reg <= '0;
            imm <= '0;
            {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, illegal, alu_ctrl} <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            read_reg1 <= rs1;
            read_reg2 <= rs2;
            write_reg <= in_instr[4:0];
            imm <= imm_d;
            {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, illegal, alu_ctrl} <= ctrl;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_instr_decode.sv
// tb_instr_decode: directed and randomized checks of instr_decode against a mnemonic-level model.
module tb_instr_decode;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, wb_valid = 1'b0, flush = 1'b0;
    logic [31:0] in_instr = '0;
    logic [4:0]  wb_reg = '0;
    logic        in_ready, out_valid, reg_write, mem_read, mem_write, mem_to_reg;
    logic        alu_src, branch, uncond_branch, illegal;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [63:0] imm;
    logic [3:0]  alu_ctrl;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    instr_decode dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .imm(imm), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .branch(branch),
        .uncond_branch(uncond_branch), .illegal(illegal), .alu_ctrl(alu_ctrl),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush)
    );

    typedef struct {
        logic rw, mr, mw, m2r, as, br, ub, ill, use2;
        logic [3:0] alu;
        logic [4:0] r1, r2, wr;
        logic [63:0] imm;
    } exp_t;

    function automatic string mnem(input logic [31:0] w);
        if (w[31:21] == 11'b10001011000) return "ADD";
        if (w[31:21] == 11'b11001011000) return "SUB";
        if (w[31:21] == 11'b10001010000) return "AND";
        if (w[31:21] == 11'b10101010000) return "ORR";
        if (w[31:21] == 11'b11010011011) return "LSL";
        if (w[31:21] == 11'b11010011010) return "LSR";
        if (w[31:21] == 11'b11111000010) return "LDUR";
        if (w[31:21] == 11'b11111000000) return "STUR";
        if (w[31:22] == 10'b1001000100) return "ADDI";
        if (w[31:22] == 10'b1101000100) return "SUBI";
        if (w[31:26] == 6'b000101) return "B";
        if (w[31:24] == 8'b10110100) return "CBZ";
        if (w[31:24] == 8'b10110101) return "CBNZ";
        return "ILL";
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        string m;
        bit rtype, itype, cb, shift, mem;
        longint d;
        m = mnem(w);
        rtype = m == "ADD" || m == "SUB" || m == "AND" || m == "ORR" || m == "LSL" || m == "LSR";
        itype = m == "ADDI" || m == "SUBI";
        cb = m == "CBZ" || m == "CBNZ";
        shift = m == "LSL" || m == "LSR";
        mem = m == "LDUR" || m == "STUR";
        e.r1 = w[9:5];
        e.wr = w[4:0];
        e.r2 = (m == "STUR" || cb) ? w[4:0] : w[20:16];
        e.use2 = (rtype && !shift) || m == "STUR" || cb;
        e.rw = rtype || itype || m == "LDUR";
        e.mr = m == "LDUR";
        e.m2r = m == "LDUR";
        e.mw = m == "STUR";
        e.as = itype || mem || shift;
        e.br = cb;
        e.ub = m == "B";
        e.ill = m == "ILL";
        e.alu = m == "AND" ? 4'd0 : m == "ORR" ? 4'd1 : (m == "ADD" || itype && m == "ADDI" || mem) ? 4'd2 :
                (m == "SUB" || m == "SUBI") ? 4'd6 : cb ? 4'd7 : m == "LSL" ? 4'd3 : m == "LSR" ? 4'd4 : 4'd0;
        e.imm = '0;
        if (itype) e.imm = {52'd0, w[21:10]};
        else if (mem) begin d = $signed(w[20:12]); e.imm = d; end
        else if (m == "B") begin d = $signed(w[25:0]); e.imm = d * 4; end
        else if (cb) begin d = $signed(w[23:5]); e.imm = d * 4; end
        else if (shift) e.imm = {58'd0, w[15:10]};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 14))
            0: w[31:21] = 11'b10001011000;
            1: w[31:21] = 11'b11001011000;
            2: w[31:21] = 11'b10001010000;
            3: w[31:21] = 11'b10101010000;
            4: w[31:21] = 11'b11010011011;
            5: w[31:21] = 11'b11010011010;
            6: w[31:21] = 11'b11111000010;
            7: w[31:21] = 11'b11111000000;
            8: w[31:22] = 10'b1001000100;
            9: w[31:22] = 10'b1101000100;
            10: w[31:26] = 6'b000101;
            11: w[31:24] = 8'b10110100;
            12: w[31:24] = 8'b10110101;
            default: ;
        endcase
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] w, input logic rdy);
        @(negedge clk);
        in_valid = 1'b1; in_instr = w; out_ready = rdy;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, in_ready, reg_write, illegal, branch, alu_ctrl, imm, write_reg} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%0b ready=%0b alu=%0h imm=%0h want all zero", out_valid, in_ready, alu_ctrl, imm);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_and_raw();
        do_reset();
        send(32'h8B030041, 1'b1);
        checks++;
        if ({out_valid, read_reg1, read_reg2, write_reg, alu_ctrl, reg_write, alu_src} !== {1'b1, 5'd2, 5'd3, 5'd1, 4'b0010, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL add_fields got v=%0b r1=%0d r2=%0d wr=%0d alu=%0h rw=%0b want 1/2/3/1/2/1", out_valid, read_reg1, read_reg2, write_reg, alu_ctrl, reg_write);
        end
        // ADD X4,X1,X2 depends on X1, which is now busy.
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h8B020024; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_stall cyc=%0d got in_ready=%0b want 0", k, in_ready); end
            @(negedge clk);
        end
        wb_valid = 1'b1; wb_reg = 5'd1;
        #1 checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL raw_wb_same_cycle got in_ready=%0b want 0", in_ready); end
        @(negedge clk);
        wb_valid = 1'b0;
        #1 checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL raw_release got in_ready=%0b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if ({out_valid, read_reg1, read_reg2, write_reg} !== {1'b1, 5'd1, 5'd2, 5'd4}) begin
            failures++;
            $display("FAIL raw_second got v=%0b r1=%0d r2=%0d wr=%0d want 1/1/2/4", out_valid, read_reg1, read_reg2, write_reg);
        end
    endtask

    task automatic test_addi_cbz();
        do_reset();
        send(32'h910010A5, 1'b1);
        checks++;
        if ({imm, alu_src, alu_ctrl, reg_write, write_reg, read_reg1} !== {64'd4, 1'b1, 4'b0010, 1'b1, 5'd5, 5'd5}) begin
            failures++;
            $display("FAIL addi got imm=%0h as=%0b alu=%0h rw=%0b wr=%0d want 4/1/2/1/5", imm, alu_src, alu_ctrl, reg_write, write_reg);
        end
        send(32'hB4FFFFE0, 1'b1);
        checks++;
        if ({read_reg2, imm, branch, reg_write, alu_ctrl, uncond_branch} !== {5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 4'b0111, 1'b0}) begin
            failures++;
            $display("FAIL cbz got r2=%0d imm=%0h br=%0b rw=%0b alu=%0h want 0/fffffffffffffffc/1/0/7", read_reg2, imm, branch, reg_write, alu_ctrl);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        send(32'h8B030041, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h910010A5; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 checks++;
            if ({in_ready, out_valid, write_reg, read_reg1, alu_ctrl, reg_write} !== {1'b0, 1'b1, 5'd1, 5'd2, 4'b0010, 1'b1}) begin
                failures++;
                $display("FAIL hold cyc=%0d got ready=%0b v=%0b wr=%0d r1=%0d alu=%0h", k, in_ready, out_valid, write_reg, read_reg1, alu_ctrl);
            end
            @(negedge clk);
        end
        flush = 1'b1; out_ready = 1'b1;
        #1 checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got %0b want 0", in_ready); end
        @(posedge clk);
        #1 checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        @(negedge clk);
        flush = 1'b0; in_instr = 32'h8B020024;
        #1 checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_busy_clear got in_ready=%0b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_illegal_and_reset_stall();
        do_reset();
        send(32'hFFFFFFFF, 1'b1);
        checks++;
        if ({out_valid, illegal, reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, alu_ctrl, imm} !== {2'b11, 7'd0, 4'd0, 64'd0}) begin
            failures++;
            $display("FAIL illegal_ones got v=%0b ill=%0b rw=%0b alu=%0h imm=%0h", out_valid, illegal, reg_write, alu_ctrl, imm);
        end
        send(32'h00000001, 1'b1);
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h8B020024;
        #1 checks++;
        if ({illegal, in_ready} !== 2'b11) begin failures++; $display("FAIL illegal_no_busy got ill=%0b in_ready=%0b want 1/1", illegal, in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        // X4 is now busy; stall a reader, then reset mid-stall.
        @(negedge clk);
        in_valid = 1'b1; in_instr = 32'h8B040086; out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checks++;
        if ({out_valid, reg_write, alu_ctrl, imm, write_reg} !== '0) begin
            failures++;
            $display("FAIL reset_mid_stall got v=%0b rw=%0b alu=%0h imm=%0h wr=%0d want 0", out_valid, reg_write, alu_ctrl, imm, write_reg);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        #1 checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got %0b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if ({out_valid, write_reg, read_reg1} !== {1'b1, 5'd6, 5'd4}) begin
            failures++;
            $display("FAIL post_reset_accept got v=%0b wr=%0d r1=%0d want 1/6/4", out_valid, write_reg, read_reg1);
        end
    endtask

    task automatic test_random();
        exp_t held, e;
        bit mval, exp_ready, acc;
        bit [31:0] mbusy, nb;
        mval = 0; mbusy = '0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            in_valid = $urandom_range(0, 3) != 0;
            in_instr = rand_instr();
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 19) == 0;
            wb_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                int s = $urandom_range(0, 31);
                for (int j = 0; j < 32; j++)
                    if (!wb_valid && mbusy[(s + j) % 32]) begin wb_valid = 1'b1; wb_reg = 5'((s + j) % 32); end
            end
            e = ref_decode(in_instr);
            exp_ready = (!mval || out_ready) && !flush && !(in_valid && (mbusy[e.r1] || (e.use2 && mbusy[e.r2])));
            #1 checks++;
            if (in_ready !== exp_ready) begin failures++; $display("FAIL rand_ready cyc=%0d instr=%h got %0b want %0b", c, in_instr, in_ready, exp_ready); end
            acc = in_valid && exp_ready;
            nb = mbusy;
            if (wb_valid) nb[wb_reg] = 1'b0;
            if (flush && mval && held.rw) nb[held.wr] = 1'b0;
            if (acc && e.rw && e.wr != 5'd31) nb[e.wr] = 1'b1;
            mbusy = nb;
            if (acc) begin held = e; mval = 1; end
            else if (flush || out_ready) mval = 0;
            @(posedge clk);
            #1 checks++;
            if (out_valid !== mval) begin failures++; $display("FAIL rand_valid cyc=%0d got %0b want %0b", c, out_valid, mval); end
            if (mval) begin
                checks++;
                if ({read_reg1, read_reg2, write_reg} !== {held.r1, held.r2, held.wr}) begin
                    failures++;
                    $display("FAIL rand_regs cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", c, read_reg1, read_reg2, write_reg, held.r1, held.r2, held.wr);
                end
                checks++;
                if ({reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, illegal, alu_ctrl} !==
                    {held.rw, held.mr, held.mw, held.m2r, held.as, held.br, held.ub, held.ill, held.alu}) begin
                    failures++;
                    $display("FAIL rand_ctrl cyc=%0d got %b%b%b%b%b%b%b%b_%h want %b%b%b%b%b%b%b%b_%h", c, reg_write, mem_read, mem_write, mem_to_reg,
                             alu_src, branch, uncond_branch, illegal, alu_ctrl, held.rw, held.mr, held.mw, held.m2r, held.as, held.br, held.ub, held.ill, held.alu);
                end
                checks++;
                if (imm !== held.imm) begin failures++; $display("FAIL rand_imm cyc=%0d got %h want %h", c, imm, held.imm); end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add_and_raw();
        test_addi_cbz();
        test_stall_flush();
        test_illegal_and_reset_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL take WORD from constants.vh (`WORD, 64), not from a local parameter.
REQ-002 Parameter SB_EN, default 1, meaning: 1 enables the RAW scoreboard stall, 0 never stalls.
REQ-003 Port clk, input, 1: single clock, all state on posedge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Ports in_valid/in_ready, input/output, 1 each: fetch handshake; in_instr, input, 32: instruction.
REQ-006 Ports out_valid/out_ready, output/input, 1 each: handshake to register_memory/execute.
REQ-007 Ports read_reg1, read_reg2, write_reg, output, 5 each: register addresses.
REQ-008 Port imm, output, WORD: extended immediate.
REQ-009 Ports reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond_branch, illegal, output, 1 each; alu_ctrl, output, 4.
REQ-010 Ports wb_valid, input, 1 and wb_reg, input, 5: writeback retire, clears scoreboard bit.
REQ-011 Port flush, input, 1: discards the held output instruction.

Function
REQ-012 Decode SHALL be: R ADD/SUB/AND/ORR/LSL/LSR [31:21]=10001011000/11001011000/10001010000/10101010000/11010011011/11010011010; I ADDI/SUBI [31:22]=1001000100/1101000100; D LDUR/STUR [31:21]=11111000010/11111000000; B [31:26]=000101; CBZ/CBNZ [31:24]=10110100/10110101.
REQ-013 read_reg1=[9:5]; read_reg2=[4:0] for STUR/CBZ/CBNZ, else [20:16]; write_reg=[4:0].
REQ-014 imm SHALL be: I zero-ext [21:10]; D sign-ext [20:12]; B sign-ext [25:0]<<2; CB sign-ext [23:5]<<2; LSL/LSR zero-ext [15:10]; else 0.
REQ-015 alu_ctrl SHALL be: AND 0000, ORR 0001, ADD/ADDI/LDUR/STUR 0010, SUB/SUBI 0110, pass-B (CB) 0111, LSL 0011, LSR 0100.
REQ-016 reg_write=1 for R, I, LDUR; mem_read/mem_to_reg=1 for LDUR; mem_write=1 for STUR; alu_src=1 for I, D, LSL/LSR; branch=1 for CB; uncond_branch=1 for B.
REQ-017 Unmatched opcode SHALL yield illegal=1 with all other control bits 0; it still passes the handshake.
REQ-018 Output SHALL be a registered stage: decoded fields appear one cycle after an accepted input (in_valid&&in_ready).
REQ-019 in_ready = (!out_valid || out_ready) && !hazard; outputs SHALL hold stable while out_valid&&!out_ready.
REQ-020 Scoreboard: 32 busy bits; accepting an instruction with reg_write=1 and write_reg!=31 SHALL set busy[write_reg].
REQ-021 hazard = SB_EN && in_valid && (busy[rs1] || (rs2 used && busy[rs2])), using registered busy only; register 31 (XZR) is never busy.
REQ-022 wb_valid SHALL clear busy[wb_reg] next edge; if same cycle an accept sets that register, set wins.
REQ-023 flush SHALL clear out_valid and clear busy bit set by the held instruction; a same-cycle input is not accepted (in_ready=0 while flush=1).

Reset
REQ-024 rst_n low SHALL immediately force out_valid=0, all busy=0, all outputs including imm and alu_ctrl=0.
REQ-025 Reset mid-stall SHALL drop the held instruction; first accept after release proceeds with no hazard.

Structure
REQ-026 Opcode patterns, alu_ctrl encodings and `WORD SHALL live in constants.vh, shared with execute.
REQ-027 One sub-module, sign_extend (combinational immediate generator per REQ-014), SHALL be instantiated; scoreboard and handshake stay in instr_decode.

Verification
REQ-028 0x8B030041 (ADD X1,X2,X3) -> next cycle read_reg1=2, read_reg2=3, write_reg=1, alu_ctrl=0010, reg_write=1, busy[1]=1.
REQ-029 0x910010A5 (ADDI X5,X5,#4) -> imm=4, alu_src=1, alu_ctrl=0010.
REQ-030 0xB4FFFFE0 (CBZ X0,-1) -> read_reg2=0, imm=0xFFFFFFFFFFFFFFFC, branch=1, reg_write=0.
REQ-031 0x8B030041 then 0x8B020024 -> in_ready=0 until wb_valid=1 wb_reg=1; accept one cycle after clear.
REQ-032 out_ready=0 for 3 cycles -> outputs stable, in_ready=0; flush -> out_valid=0, busy bit cleared.
REQ-033 0xFFFFFFFF -> illegal=1, controls 0, no busy bit set; rst_n low mid-stall -> out_valid=0 immediately.
